alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: bus-side initiator for the ALU. It accepts one operation
// request, writes the B operand to the ALU over ibus with an nwalu strobe
// (binary ops only), selects the ALU unit via runit, and captures the result
// and status flags from ibus.
//
// Ports:
//   clk, nreset         clock, asynchronous active-low reset
//   req, req_op, req_b  request strobe, ALU unit code, B operand
//   busy                high from the acceptance edge until DONE ends
//   done, err           one-cycle pulses: result valid / illegal op rejected
//   fault               flag contradicted the op, valid alongside done
//   result, carry       captured ALU output and ADD carry
//   runit, nwalu        ALU unit select (0 = idle), active-low B write strobe
//   ibus_out, ibus_oe   ibus drive data and enable
//   ibus_in             ibus as seen by this block
//   nfltadd, isroll, roll16  ALU status inputs
module alu_op_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        req,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        fault,
  output logic [15:0] result,
  output logic        carry,
  output logic [3:0]  runit,
  output logic        nwalu,
  output logic [15:0] ibus_out,
  output logic        ibus_oe,
  input  logic [15:0] ibus_in,
  input  logic        nfltadd,
  input  logic        isroll,
  input  logic        roll16
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b1000;
  localparam logic [OP_W-1:0] OP_AND  = 4'b1001;
  localparam logic [OP_W-1:0] OP_OR   = 4'b1010;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b1011;
  localparam logic [OP_W-1:0] OP_ROLL = 4'b0100;
  localparam logic [OP_W-1:0] OP_NOT  = 4'b0101;

  // OP lasts SETTLE cycles: the counter is loaded with SETTLE-1 and exits at 0.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    WRITE   = 3'd2,
    RELEASE = 3'd3,
    OP      = 3'd4,
    CAPTURE = 3'd5,
    DONE    = 3'd6,
    REJECT  = 3'd7
  } state_t;

  state_t             state_q, state_nx;
  logic [OP_W-1:0]    op_q, op_nx;
  logic [DATA_W-1:0]  b_q, b_nx;
  logic [CNT_W-1:0]   cnt_q, cnt_nx;

  logic               busy_nx, done_nx, err_nx, fault_nx, carry_nx;
  logic [DATA_W-1:0]  result_nx, ibus_out_nx;
  logic [OP_W-1:0]    runit_nx;
  logic               nwalu_nx, ibus_oe_nx;
  logic               legal, drive;

  // Next state plus next values of every registered output. Outputs are
  // decoded from the next state so each one is valid in the cycle of its state.
  always_comb begin
    state_nx  = state_q;
    op_nx     = op_q;
    b_nx      = b_q;
    cnt_nx    = cnt_q;
    result_nx = result;
    carry_nx  = carry;
    fault_nx  = 1'b0;
    legal     = 1'b0;

    case (req_op)
      OP_ADD, OP_AND, OP_OR, OP_XOR, OP_ROLL, OP_NOT: legal = 1'b1;
      default:                                        legal = 1'b0;
    endcase

    case (state_q)
      IDLE: begin
        if (req) begin
          if (legal) begin
            op_nx = req_op;
            b_nx  = req_b;
            // Binary ops need B loaded first; unary ops go straight to OP.
            if (req_op[3]) begin
              state_nx = DRIVE;
            end else begin
              state_nx = OP;
              cnt_nx   = SETTLE_LOAD;
            end
          end else begin
            state_nx = REJECT;
          end
        end
      end
      DRIVE:   state_nx = WRITE;
      WRITE:   state_nx = RELEASE;
      RELEASE: begin
        state_nx = OP;
        cnt_nx   = SETTLE_LOAD;
      end
      OP: begin
        if (cnt_q == '0) begin
          state_nx = CAPTURE;
        end else begin
          cnt_nx = cnt_q - CNT_W'(1);
        end
      end
      CAPTURE: begin
        state_nx  = DONE;
        result_nx = ibus_in;
        carry_nx  = (op_q == OP_ADD) & ~nfltadd;
        fault_nx  = (~nfltadd & (op_q != OP_ADD)) |
                    ((isroll | roll16) & (op_q != OP_ROLL));
      end
      DONE:    state_nx = IDLE;
      REJECT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    drive       = (state_nx == DRIVE) || (state_nx == WRITE);
    busy_nx     = (state_nx != IDLE);
    done_nx     = (state_nx == DONE);
    err_nx      = (state_nx == REJECT);
    ibus_oe_nx  = drive;
    ibus_out_nx = drive ? b_nx : '0;
    nwalu_nx    = (state_nx != WRITE);
    runit_nx    = ((state_nx == OP) || (state_nx == CAPTURE)) ? op_nx : '0;
  end

  // State and output registers; reset releases the bus and ends nwalu at once.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      fault    <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      runit    <= '0;
      nwalu    <= 1'b1;
      ibus_out <= '0;
      ibus_oe  <= 1'b0;
    end else begin
      state_q  <= state_nx;
      op_q     <= op_nx;
      b_q      <= b_nx;
      cnt_q    <= cnt_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      err      <= err_nx;
      fault    <= fault_nx;
      result   <= result_nx;
      carry    <= carry_nx;
      runit    <= runit_nx;
      nwalu    <= nwalu_nx;
      ibus_out <= ibus_out_nx;
      ibus_oe  <= ibus_oe_nx;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: a behavioural ALU on the far side of ibus,
// a reference model feeding an expected-result queue, and timing checks.
module tb_alu_op_sequencer #(
  parameter int unsigned SETTLE = 3
);

  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b1010;
  localparam logic [3:0] OP_XOR  = 4'b1011;
  localparam logic [3:0] OP_ROLL = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [15:0] DELTA  = 16'h1357;
  localparam int BIN_LAT = 5 + SETTLE;
  localparam int UN_LAT  = SETTLE + 2;
  localparam int N_RAND  = 300;

  typedef struct packed {
    logic [15:0] result;
    logic        carry;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   inv_viol = 0;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        req = 1'b0;
  logic [3:0]  req_op = 4'b0;
  logic [15:0] req_b = 16'h0;
  logic        busy, done, err, fault, carry, nwalu, ibus_oe;
  logic [15:0] result, ibus_out;
  logic [3:0]  runit;

  // ALU model state
  logic [15:0] ac = 16'h0;
  logic [15:0] alu_b = 16'h0;
  logic [15:0] alu_y, ibus;
  logic [16:0] alu_sum;
  logic        alu_nflt, alu_isroll, alu_roll16;
  logic        force_nflt = 1'b0;
  logic        force_isroll = 1'b0;
  logic        nfltadd_s, isroll_s;
  logic [15:0] prev_result = 16'h0;
  logic        prev_carry = 1'b0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.SETTLE(SETTLE)) dut (
    .clk(clk), .nreset(nreset), .req(req), .req_op(req_op), .req_b(req_b),
    .busy(busy), .done(done), .err(err), .fault(fault), .result(result),
    .carry(carry), .runit(runit), .nwalu(nwalu), .ibus_out(ibus_out),
    .ibus_oe(ibus_oe), .ibus_in(ibus), .nfltadd(nfltadd_s),
    .isroll(isroll_s), .roll16(alu_roll16)
  );

  always_comb begin
    alu_sum    = {1'b0, ac} + {1'b0, alu_b};
    alu_y      = 16'h0;
    alu_nflt   = 1'b1;
    alu_isroll = 1'b0;
    alu_roll16 = 1'b0;
    case (runit)
      OP_ADD:  begin alu_y = alu_sum[15:0]; alu_nflt = ~alu_sum[16]; end
      OP_AND:  alu_y = ac & alu_b;
      OP_OR:   alu_y = ac | alu_b;
      OP_XOR:  alu_y = ac ^ alu_b;
      OP_ROLL: begin alu_y = {ac[14:0], ac[15]}; alu_isroll = 1'b1; alu_roll16 = ac[15]; end
      OP_NOT:  alu_y = ~ac;
      default: ;
    endcase
  end

  assign nfltadd_s = alu_nflt & ~force_nflt;
  assign isroll_s  = alu_isroll | force_isroll;
  // Undriven bus reads as a marker pattern so a premature capture shows up.
  assign ibus = ibus_oe ? ibus_out : ((runit != 4'b0) ? alu_y : 16'hA5A5);

  // The ALU B register loads while nwalu is low.
  always @(posedge clk) if (!nwalu) alu_b <= ibus;

  // Bus invariants and result stability, tallied for a final comparison.
  always @(negedge clk) begin
    if (ibus_oe && runit != 4'b0) inv_viol++;
    if (!nwalu && !ibus_oe) inv_viol++;
    if (nreset && !done && (result !== prev_result || carry !== prev_carry)) inv_viol++;
    prev_result = result;
    prev_carry  = carry;
  end

  function automatic logic [15:0] ref_result(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
    logic [15:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_ROLL: r = {a[14:0], a[15]};
      OP_NOT:  r = ~a;
      default: r = 16'h0;
    endcase
    return r;
  endfunction

  function automatic logic ref_carry(input logic [3:0] op, input logic [15:0] a,
                                     input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (op == OP_ADD) ? s[16] : 1'b0;
  endfunction

  // Issue one legal op, check its bus timing, and compare the captured result.
  task automatic run_op(input logic [3:0] op, input logic [15:0] b, input logic [15:0] a,
                        input logic exp_fault, input string name);
    exp_t e, got;
    int   done_cyc, nw_cnt, nw_first, oe_cnt, busy_cnt, lat;
    logic binop;
    binop = op[3];
    ac = a;
    e.result = ref_result(op, a, b);
    e.carry  = ref_carry(op, a, b);
    e.fault  = exp_fault;
    sb.push_back(e);
    @(negedge clk);
    req = 1'b1; req_op = op; req_b = b;
    @(posedge clk);
    #1 req = 1'b0; req_op = 4'b0; req_b = 16'($urandom);
    done_cyc = 0; nw_cnt = 0; nw_first = 0; oe_cnt = 0; busy_cnt = 0;
    for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (!nwalu) begin nw_cnt++; if (nw_first == 0) nw_first = cyc; end
      if (ibus_oe) oe_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = cyc;
        got = {result, carry, fault};
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s sb_empty: done with no expected entry", name);
        end else begin
          e = sb.pop_front();
          checks++;
          if (got !== e) begin
            errors++;
            $display("FAIL %s result: got %h c=%b f=%b, expected %h c=%b f=%b",
                     name, got.result, got.carry, got.fault, e.result, e.carry, e.fault);
          end
        end
      end
    end
    lat = binop ? BIN_LAT : UN_LAT;
    checks++;
    if (done_cyc != lat || busy_cnt != lat) begin
      errors++;
      $display("FAIL %s latency: done cycle %0d busy %0d, expected %0d", name, done_cyc, busy_cnt, lat);
    end
    checks++;
    if (binop ? (nw_cnt != 1 || nw_first != 2 || oe_cnt != 2) : (nw_cnt != 0 || oe_cnt != 0)) begin
      errors++;
      $display("FAIL %s strobe: nwalu low %0d cycles from %0d, oe %0d cycles", name, nw_cnt, nw_first, oe_cnt);
    end
    @(negedge clk);
    checks++;
    if ({done, busy, fault} !== 3'b000) begin
      errors++;
      $display("FAIL %s post_done: done=%b busy=%b fault=%b, expected 000", name, done, busy, fault);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, err, fault, carry, nwalu, ibus_oe} !== 7'b0000010) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, expected 0000010", {busy, done, err, fault, carry, nwalu, ibus_oe});
    end
    checks++;
    if (result !== 16'h0 || ibus_out !== 16'h0 || runit !== 4'h0) begin
      errors++;
      $display("FAIL reset_data: result=%h ibus_out=%h runit=%h, expected 0", result, ibus_out, runit);
    end
    nreset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || runit !== 4'h0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b runit=%h, expected 0", busy, runit);
    end
  endtask

  task automatic test_binary();
    run_op(OP_OR,  16'h5431, 16'h0A0C, 1'b0, "or");
    run_op(OP_ADD, 16'h0001, 16'hFFFF, 1'b0, "add_carry");
    run_op(OP_ADD, 16'h0001, 16'h1234, 1'b0, "add");
    run_op(OP_AND, 16'hF0F0, 16'h3C3C, 1'b0, "and");
    run_op(OP_XOR, 16'hFFFF, 16'h1234, 1'b0, "xor");
  endtask

  task automatic test_unary();
    run_op(OP_NOT,  16'h0000, 16'h00FF, 1'b0, "not");
    run_op(OP_ROLL, 16'h0000, 16'h8001, 1'b0, "roll_msb");
    run_op(OP_ROLL, 16'h0000, 16'h1234, 1'b0, "roll");
  endtask

  task automatic test_illegal();
    logic [3:0] bad [3];
    int err_cyc, err_cnt, busy_cnt, moved;
    bad = '{4'b0011, 4'b0000, 4'b1111};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req = 1'b1; req_op = bad[k]; req_b = 16'hBEEF;
      @(posedge clk);
      #1 req = 1'b0;
      err_cyc = 0; err_cnt = 0; busy_cnt = 0; moved = 0;
      for (int cyc = 1; cyc <= 8; cyc++) begin
        @(negedge clk);
        if (busy) busy_cnt++;
        if (err) begin err_cnt++; if (err_cyc == 0) err_cyc = cyc; end
        if (runit != 4'b0 || !nwalu || ibus_oe || done) moved++;
      end
      checks++;
      if (err_cyc != 1 || err_cnt != 1 || busy_cnt != 1 || moved != 0) begin
        errors++;
        $display("FAIL illegal_%b: err at %0d x%0d busy %0d pins moved %0d, expected 1 x1 busy 1 moved 0",
                 bad[k], err_cyc, err_cnt, busy_cnt, moved);
      end
    end
  endtask

  task automatic test_fault();
    force_nflt = 1'b1;
    run_op(OP_OR, 16'h00F0, 16'h0F00, 1'b1, "fault_nflt_or");
    force_nflt = 1'b0;
    force_isroll = 1'b1;
    run_op(OP_NOT, 16'h0000, 16'h5555, 1'b1, "fault_isroll_not");
    force_isroll = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int rc, seen_done;
    ac = 16'h1111;
    @(negedge clk);
    req = 1'b1; req_op = OP_ADD; req_b = 16'h2222;
    @(posedge clk);
    #1 req = 1'b0;
    rc = (SETTLE > 1) ? 5 : 4;
    repeat (rc) @(negedge clk);
    checks++;
    if (runit !== OP_ADD) begin
      errors++;
      $display("FAIL rst_mid_pre: runit=%b in cycle %0d, expected %b", runit, rc, OP_ADD);
    end
    nreset = 1'b0;
    #1;
    checks++;
    if ({runit, ibus_oe, nwalu, busy, result} !== {4'b0, 1'b0, 1'b1, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL rst_mid_abort: runit=%b oe=%b nwalu=%b busy=%b result=%h", runit, ibus_oe, nwalu, busy, result);
    end
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    seen_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL rst_mid_nodone: %0d busy/done cycles after abort, expected 0", seen_done);
    end
    run_op(OP_ADD, 16'h0001, 16'h1234, 1'b0, "post_reset_add");
  endtask

  task automatic test_back_to_back();
    exp_t e, got;
    int rises, dones, d1, d2, late;
    logic prev_busy;
    ac = 16'h0F0F;
    e.result = ref_result(OP_XOR, 16'h0F0F, 16'h3030);
    e.carry  = 1'b0;
    e.fault  = 1'b0;
    sb.push_back(e);
    sb.push_back(e);
    @(negedge clk);
    req = 1'b1; req_op = OP_XOR; req_b = 16'h3030;
    rises = 0; dones = 0; d1 = 0; d2 = 0; prev_busy = 1'b0;
    for (int cyc = 1; cyc <= 60 && dones < 2; cyc++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        rises++;
        if (rises == 2) req = 1'b0;
      end
      prev_busy = busy;
      if (done) begin
        dones++;
        if (dones == 1) d1 = cyc; else d2 = cyc;
        got = {result, carry, fault};
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b sb_empty: done with no expected entry");
        end else begin
          e = sb.pop_front();
          checks++;
          if (got !== e) begin
            errors++;
            $display("FAIL b2b result: got %h c=%b f=%b, expected %h c=%b f=%b",
                     got.result, got.carry, got.fault, e.result, e.carry, e.fault);
          end
        end
      end
    end
    checks++;
    if (dones != 2 || (d2 - d1) != 6 + SETTLE) begin
      errors++;
      $display("FAIL b2b pitch: %0d dones, pitch %0d, expected 2 and %0d", dones, d2 - d1, 6 + SETTLE);
    end
    req = 1'b0;
    late = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) late++;
    end
    checks++;
    if (late != 0) begin
      errors++;
      $display("FAIL b2b extra_accept: busy %0d cycles after release, expected 0", late);
    end
  endtask

  task automatic test_random();
    logic [3:0]  legal [6];
    logic [3:0]  op;
    logic [15:0] b, a;
    legal = '{OP_ADD, OP_AND, OP_OR, OP_XOR, OP_ROLL, OP_NOT};
    b = 16'h0101;
    for (int i = 0; i < N_RAND; i++) begin
      op = legal[$urandom_range(0, 5)];
      a  = 16'($urandom);
      b  = b + DELTA;
      run_op(op, b, a, 1'b0, "rand");
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (inv_viol != 0) begin
      errors++;
      $display("FAIL invariants: %0d bus/stability violations, expected 0", inv_viol);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected results never produced", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_binary();
    test_unary();
    test_illegal();
    test_fault();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
